// File: rtl/uart_tx_fifo_if.sv
// Producer-side bundle for the UART transmitter: byte push handshake, FIFO status and serial line.
`timescale 1ns/1ps
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             wr_en;
  logic [7:0]       tx_data;
  logic             TX;
  logic             full;
  logic             empty;
  logic             busy;
  logic             tx_done;
  logic [CNT_W-1:0] count;

  modport master (
    output wr_en, tx_data,
    input  TX, full, empty, busy, tx_done, count
  );

  modport slave (
    input  wr_en, tx_data,
    output TX, full, empty, busy, tx_done, count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; queued frames leave back-to-back with no idle gap.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 2604,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [11:0]      BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, TRANSMIT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic [9:0]       shift_q;
  logic [11:0]      baud_q;
  logic [3:0]       bit_q;
  logic             push, load, bit_tick, frame_end;

  // Next state: a frame is loaded from IDLE, or chained directly at the final stop-bit cycle.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    push      = bus.wr_en && !full_q;
    bit_tick  = (state_q == TRANSMIT) && (baud_q == 12'd0);
    frame_end = bit_tick && (bit_q == 4'd9);
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          load    = 1'b1;
          state_d = TRANSMIT;
        end
      end
      TRANSMIT: begin
        if (frame_end) begin
          if (!empty_q) load    = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + CNT_W'(push) - CNT_W'(load);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Flags are registered from the next count so they move on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      bit_q    <= 4'd0;
      baud_q   <= 12'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
      if (load) begin
        bit_q  <= 4'd0;
        baud_q <= BAUD_LAST;
      end else if (bit_tick) begin
        bit_q  <= bit_q + 1'b1;
        baud_q <= BAUD_LAST;
      end else if (state_q == TRANSMIT) begin
        baud_q <= baud_q - 1'b1;
      end
    end
  end

  // Storage and shifter carry no reset; the line is gated by the FSM state instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.tx_data;
    if (load)          shift_q <= {1'b1, mem[rd_ptr_q], 1'b0};
    else if (bit_tick) shift_q <= {1'b1, shift_q[9:1]};
  end

  assign bus.TX      = (state_q == TRANSMIT) ? shift_q[0] : 1'b1;
  assign bus.busy    = (state_q == TRANSMIT);
  assign bus.tx_done = frame_end;
  assign bus.full    = full_q;
  assign bus.empty   = empty_q;
  assign bus.count   = count_q;
endmodule
